// File: rtl/core_control_fsm_pkg.sv
// Shared types and constants for the RV32I multi-cycle control sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: state encoding, pc_src / wb_sel encodings, trap cause codes,
// one-hot opcode bit indices, the latched instruction-class struct and
// the helper that derives that struct from the decoder's one-hot opcode.

package core_ctrl_pkg;

    // Sequencer states; the numeric values are visible on state_dbg.
    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        DECODE     = 3'd2,
        EXECUTE    = 3'd3,
        MEM_REQ    = 3'd4,
        MEM_WAIT   = 3'd5,
        WRITEBACK  = 3'd6,
        TRAP       = 3'd7
    } state_e;

    // Next-PC mux select.
    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,   // PC + imm (taken branch, JAL)
        PC_JALR   = 2'd2,   // rs1 + imm
        PC_TRAP   = 2'd3    // trap vector
    } pc_src_e;

    // Register-file write-data mux select.
    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_e;

    // Trap cause codes reported on trap_cause.
    localparam logic [2:0] CAUSE_NONE     = 3'd0;
    localparam logic [2:0] CAUSE_FETCH    = 3'd1;  // fetch bus error or fetch timeout
    localparam logic [2:0] CAUSE_ILLEGAL  = 3'd2;
    localparam logic [2:0] CAUSE_SYSTEM   = 3'd3;
    localparam logic [2:0] CAUSE_DTIMEOUT = 3'd4;

    // Bit positions in the decoder's one-hot opcode[6:2] vector.
    localparam int OPB_LOAD     = 0;
    localparam int OPB_MISC_MEM = 3;
    localparam int OPB_OP_IMM   = 4;
    localparam int OPB_AUIPC    = 5;
    localparam int OPB_STORE    = 8;
    localparam int OPB_OP       = 12;
    localparam int OPB_LUI      = 13;
    localparam int OPB_BRANCH   = 24;
    localparam int OPB_JALR     = 25;
    localparam int OPB_JAL      = 27;
    localparam int OPB_SYSTEM   = 28;

    // Any opcode bit outside this mask is an illegal instruction.
    localparam logic [31:0] OPC_SUPPORTED_MASK =
        (32'd1 << OPB_LOAD)   | (32'd1 << OPB_MISC_MEM) | (32'd1 << OPB_OP_IMM) |
        (32'd1 << OPB_AUIPC)  | (32'd1 << OPB_STORE)    | (32'd1 << OPB_OP)     |
        (32'd1 << OPB_LUI)    | (32'd1 << OPB_BRANCH)   | (32'd1 << OPB_JALR)   |
        (32'd1 << OPB_JAL)    | (32'd1 << OPB_SYSTEM);

    // Instruction class captured once in DECODE so later states do not
    // depend on the decoder outputs staying glitch-free.
    typedef struct packed {
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_misc_mem;
        logic is_system;
        logic is_jal;
        logic is_jalr;
    } op_class_t;

    function automatic op_class_t classify_opcode(input logic [31:0] onehot);
        op_class_t c;
        c.is_load     = onehot[OPB_LOAD];
        c.is_store    = onehot[OPB_STORE];
        c.is_branch   = onehot[OPB_BRANCH];
        c.is_misc_mem = onehot[OPB_MISC_MEM];
        c.is_system   = onehot[OPB_SYSTEM];
        c.is_jal      = onehot[OPB_JAL];
        c.is_jalr     = onehot[OPB_JALR];
        return c;
    endfunction

endpackage

// File: rtl/core_control_fsm_timeout.sv
// Memory-wait watchdog: counts wait cycles and flags the cycle the limit is reached.
// Latency: o_done is combinational in the cycle the count reaches MEM_TIMEOUT.
// Backpressure: none; caller gates i_enable off when a response is present.
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (clears the count)
//   i_clear     : zero the count (entry into a wait state)
//   i_enable    : a wait-state cycle with no response
//   o_done      : this enabled cycle is the MEM_TIMEOUT-th; 0 when MEM_TIMEOUT is 0

module ctrl_timeout_counter #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_done
);

    localparam int          CW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);
    localparam bit          ENABLED = (MEM_TIMEOUT != 0);

    logic [CW-1:0] r_count;
    logic [CW:0]   w_count_inc;

    // One extra bit so the increment cannot wrap when LIMIT is all ones.
    assign w_count_inc = {1'b0, r_count} + {{CW{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= w_count_inc[CW-1:0];
        end
    end

    // The count "reaches" the limit on the enabled cycle whose increment
    // would land on it, so a response in that same cycle (enable low) wins.
    assign o_done = ENABLED && i_enable && (w_count_inc >= {1'b0, LIMIT});

endmodule

// File: rtl/core_control_fsm.sv
// RV32I multi-cycle control sequencer: fetch, decode classify, memory, writeback, trap.
// Latency: ALU op 5 cycles, load 7 cycles with zero-wait memories; one instruction in flight.
// Backpressure: imem/dmem requests held until ready; waits bounded by MEM_TIMEOUT then trap.
//
// Ports:
//   clk, rst_n                         : core clock, synchronous active-low reset
//   imem_req_valid/ready               : fetch request handshake
//   imem_resp_valid/fault              : fetch response (fault qualified by valid)
//   ir_load                            : capture fetch data into the IR
//   instr_is_32, opcode_decode,
//   rd_address, branch_taken           : decoder / comparator inputs
//   dmem_req_valid/write/ready         : data request handshake (write = store)
//   dmem_resp_valid                    : load data / store ack
//   reg_write, wb_sel                  : register-file write enable and source
//   pc_write, pc_src                   : PC update strobe and source
//   trap_valid, trap_cause             : trap pulse and sticky last cause
//   retire, retire_count               : completion pulse and wrapping count
//   state_dbg                          : current state encoding

module core_control_fsm
    import core_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    input  logic                imem_resp_valid,
    input  logic                imem_resp_fault,
    output logic                ir_load,
    input  logic                instr_is_32,
    input  logic [31:0]         opcode_decode,
    input  logic [4:0]          rd_address,
    input  logic                branch_taken,
    output logic                dmem_req_valid,
    output logic                dmem_req_write,
    input  logic                dmem_req_ready,
    input  logic                dmem_resp_valid,
    output logic                reg_write,
    output logic [1:0]          wb_sel,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                trap_valid,
    output logic [2:0]          trap_cause,
    output logic                retire,
    output logic [RETIRE_W-1:0] retire_count,
    output logic [2:0]          state_dbg
);

    state_e              r_state;
    state_e              w_state_nxt;
    op_class_t           r_op;
    logic [2:0]          r_trap_cause;
    logic [2:0]          w_trap_cause_nxt;
    logic [RETIRE_W-1:0] r_retire_count;

    logic                w_tmo_clear;
    logic                w_tmo_enable;
    logic                w_tmo_done;
    logic                w_decode_illegal;

    logic                w_imem_req_valid;
    logic                w_ir_load;
    logic                w_dmem_req_valid;
    logic                w_dmem_req_write;
    logic                w_reg_write;
    wb_sel_e             w_wb_sel;
    logic                w_pc_write;
    pc_src_e             w_pc_src;
    logic                w_trap_valid;
    logic                w_retire;

    // ------------------------------------------------------------------
    // Wait-state watchdog
    // ------------------------------------------------------------------
    assign w_tmo_clear  = ((r_state == FETCH_REQ) && imem_req_ready) ||
                          ((r_state == MEM_REQ)   && dmem_req_ready);
    assign w_tmo_enable = ((r_state == FETCH_WAIT) && !imem_resp_valid) ||
                          ((r_state == MEM_WAIT)   && !dmem_resp_valid);

    ctrl_timeout_counter #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_tmo_clear),
        .i_enable (w_tmo_enable),
        .o_done   (w_tmo_done)
    );

    // Compressed encodings alias opcode bit 0 (LOAD), so the width check
    // must veto the one-hot before it is trusted.
    assign w_decode_illegal = !instr_is_32 ||
                              ((opcode_decode & OPC_SUPPORTED_MASK) == 32'd0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FETCH_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_trap_cause_nxt = r_trap_cause;
        case (r_state)
            FETCH_REQ: begin
                if (imem_req_ready) begin
                    w_state_nxt = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_resp_valid) begin
                    if (imem_resp_fault) begin
                        w_state_nxt      = TRAP;
                        w_trap_cause_nxt = CAUSE_FETCH;
                    end else begin
                        w_state_nxt = DECODE;
                    end
                end else if (w_tmo_done) begin
                    w_state_nxt      = TRAP;
                    w_trap_cause_nxt = CAUSE_FETCH;
                end
            end
            DECODE: begin
                if (w_decode_illegal) begin
                    w_state_nxt      = TRAP;
                    w_trap_cause_nxt = CAUSE_ILLEGAL;
                end else begin
                    w_state_nxt = EXECUTE;
                end
            end
            EXECUTE: begin
                if (r_op.is_load || r_op.is_store) begin
                    w_state_nxt = MEM_REQ;
                end else if (r_op.is_system) begin
                    w_state_nxt      = TRAP;
                    w_trap_cause_nxt = CAUSE_SYSTEM;
                end else if (r_op.is_branch || r_op.is_misc_mem) begin
                    w_state_nxt = FETCH_REQ;
                end else begin
                    w_state_nxt = WRITEBACK;
                end
            end
            MEM_REQ: begin
                if (dmem_req_ready) begin
                    w_state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_resp_valid) begin
                    w_state_nxt = r_op.is_load ? WRITEBACK : FETCH_REQ;
                end else if (w_tmo_done) begin
                    w_state_nxt      = TRAP;
                    w_trap_cause_nxt = CAUSE_DTIMEOUT;
                end
            end
            WRITEBACK: w_state_nxt = FETCH_REQ;
            TRAP:      w_state_nxt = FETCH_REQ;
            default:   w_state_nxt = FETCH_REQ;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (Moore on r_state plus the qualifying inputs).
    // Everything is held at zero while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        w_imem_req_valid = 1'b0;
        w_ir_load        = 1'b0;
        w_dmem_req_valid = 1'b0;
        w_dmem_req_write = 1'b0;
        w_reg_write      = 1'b0;
        w_wb_sel         = WB_ALU;
        w_pc_write       = 1'b0;
        w_pc_src         = PC_PLUS4;
        w_trap_valid     = 1'b0;
        w_retire         = 1'b0;
        if (rst_n) begin
            case (r_state)
                FETCH_REQ: begin
                    w_imem_req_valid = 1'b1;
                end
                FETCH_WAIT: begin
                    w_ir_load = imem_resp_valid && !imem_resp_fault;
                end
                EXECUTE: begin
                    if (r_op.is_load || r_op.is_store || r_op.is_system) begin
                        w_retire = 1'b0;
                    end else if (r_op.is_branch) begin
                        w_pc_write = 1'b1;
                        w_pc_src   = branch_taken ? PC_BRANCH : PC_PLUS4;
                        w_retire   = 1'b1;
                    end else if (r_op.is_misc_mem) begin
                        // FENCE is a no-op for a single in-order core.
                        w_pc_write = 1'b1;
                        w_pc_src   = PC_PLUS4;
                        w_retire   = 1'b1;
                    end
                end
                MEM_REQ: begin
                    w_dmem_req_valid = 1'b1;
                    w_dmem_req_write = r_op.is_store;
                end
                MEM_WAIT: begin
                    // Stores complete on the ack; loads finish in WRITEBACK.
                    if (dmem_resp_valid && r_op.is_store) begin
                        w_pc_write = 1'b1;
                        w_pc_src   = PC_PLUS4;
                        w_retire   = 1'b1;
                    end
                end
                WRITEBACK: begin
                    w_reg_write = (rd_address != 5'd0);
                    if (r_op.is_load) begin
                        w_wb_sel = WB_LOAD;
                    end else if (r_op.is_jal || r_op.is_jalr) begin
                        w_wb_sel = WB_PC4;
                    end
                    w_pc_write = 1'b1;
                    if (r_op.is_jal) begin
                        w_pc_src = PC_BRANCH;
                    end else if (r_op.is_jalr) begin
                        w_pc_src = PC_JALR;
                    end
                    w_retire = 1'b1;
                end
                TRAP: begin
                    w_trap_valid = 1'b1;
                    w_pc_write   = 1'b1;
                    w_pc_src     = PC_TRAP;
                end
                default: begin
                    w_retire = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Instruction class, trap cause and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op           <= '0;
            r_trap_cause   <= CAUSE_NONE;
            r_retire_count <= '0;
        end else begin
            if (r_state == DECODE) begin
                r_op <= classify_opcode(opcode_decode);
            end
            // Only changes on a transition into TRAP, then holds.
            r_trap_cause <= w_trap_cause_nxt;
            if (w_retire) begin
                r_retire_count <= r_retire_count + RETIRE_W'(1);
            end
        end
    end

    assign imem_req_valid = w_imem_req_valid;
    assign ir_load        = w_ir_load;
    assign dmem_req_valid = w_dmem_req_valid;
    assign dmem_req_write = w_dmem_req_write;
    assign reg_write      = w_reg_write;
    assign wb_sel         = w_wb_sel;
    assign pc_write       = w_pc_write;
    assign pc_src         = w_pc_src;
    assign trap_valid     = w_trap_valid;
    assign trap_cause     = r_trap_cause;
    assign retire         = w_retire;
    assign retire_count   = r_retire_count;
    assign state_dbg      = r_state;

endmodule

// File: tb/tb_core_control_fsm.sv
// Directed bench for core_control_fsm built with MEM_TIMEOUT=4 and RETIRE_W=2.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.

module tb_core_control_fsm;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic        imem_resp_fault;
    logic        ir_load;
    logic        instr_is_32;
    logic [31:0] opcode_decode;
    logic [4:0]  rd_address;
    logic        branch_taken;
    logic        dmem_req_valid;
    logic        dmem_req_write;
    logic        dmem_req_ready;
    logic        dmem_resp_valid;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        trap_valid;
    logic [2:0]  trap_cause;
    logic        retire;
    logic [1:0]  retire_count;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] OPC_LOAD   = 32'h0000_0001;
    localparam logic [31:0] OPC_OP_IMM = 32'h0000_0010;
    localparam logic [31:0] OPC_STORE  = 32'h0000_0100;
    localparam logic [31:0] OPC_BRANCH = 32'h0100_0000;
    localparam logic [31:0] OPC_JAL    = 32'h0800_0000;
    localparam logic [31:0] OPC_SYSTEM = 32'h1000_0000;
    localparam logic [31:0] OPC_BAD    = 32'h8000_0000;

    core_control_fsm #(
        .MEM_TIMEOUT (4),
        .RETIRE_W    (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_fault (imem_resp_fault),
        .ir_load         (ir_load),
        .instr_is_32     (instr_is_32),
        .opcode_decode   (opcode_decode),
        .rd_address      (rd_address),
        .branch_taken    (branch_taken),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_write  (dmem_req_write),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_resp_valid (dmem_resp_valid),
        .reg_write       (reg_write),
        .wb_sel          (wb_sel),
        .pc_write        (pc_write),
        .pc_src          (pc_src),
        .trap_valid      (trap_valid),
        .trap_cause      (trap_cause),
        .retire          (retire),
        .retire_count    (retire_count),
        .state_dbg       (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at a FETCH_REQ cycle; returns at the start of the DECODE cycle.
    task automatic fetch_instr(input logic [31:0] opc, input logic [4:0] rd, input logic is32);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        opcode_decode   = opc;
        rd_address      = rd;
        instr_is_32     = is32;
        @(negedge clk);
        imem_resp_valid = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_fault = 1'b0;
        instr_is_32     = 1'b0;
        opcode_decode   = 32'd0;
        rd_address      = 5'd0;
        branch_taken    = 1'b0;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        #1;
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_retire_count", 32'(retire_count), 32'd0);
        chk("rst_trap_cause", 32'(trap_cause), 32'd0);
        chk("rst_imem_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_pc_write", 32'(pc_write), 32'd0);

        // ---------------- ADDI x5, zero-wait imem ----------------
        @(negedge clk);
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        #1;
        chk("addi_c1_imem_req", 32'(imem_req_valid), 32'd1);
        chk("addi_c1_retire", 32'(retire), 32'd0);
        @(negedge clk);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        instr_is_32     = 1'b1;
        opcode_decode   = OPC_OP_IMM;
        rd_address      = 5'd5;
        #1;
        chk("addi_c2_state", 32'(state_dbg), 32'd1);
        chk("addi_c2_ir_load", 32'(ir_load), 32'd1);
        @(negedge clk);
        imem_resp_valid = 1'b0;
        #1;
        chk("addi_c3_state", 32'(state_dbg), 32'd2);
        chk("addi_c3_retire", 32'(retire), 32'd0);
        @(negedge clk);
        #1;
        chk("addi_c4_state", 32'(state_dbg), 32'd3);
        chk("addi_c4_retire", 32'(retire), 32'd0);
        @(negedge clk);
        #1;
        chk("addi_c5_retire", 32'(retire), 32'd1);
        chk("addi_c5_reg_write", 32'(reg_write), 32'd1);
        chk("addi_c5_wb_sel", 32'(wb_sel), 32'd0);
        chk("addi_c5_pc_src", 32'(pc_src), 32'd0);
        chk("addi_c5_pc_write", 32'(pc_write), 32'd1);
        @(negedge clk);
        #1;
        chk("addi_next_state", 32'(state_dbg), 32'd0);
        chk("addi_retire_count", 32'(retire_count), 32'd1);

        // ---------------- LOAD x0, dmem ready after 3 cycles, resp 2 later ----------------
        fetch_instr(OPC_LOAD, 5'd0, 1'b1);
        #1;
        chk("load_decode_state", 32'(state_dbg), 32'd2);
        @(negedge clk);
        #1;
        chk("load_exec_state", 32'(state_dbg), 32'd3);
        chk("load_exec_dreq", 32'(dmem_req_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dmem_req_ready = (i == 3);
            #1;
            chk("load_dreq_held", 32'(dmem_req_valid), 32'd1);
            chk("load_dreq_write", 32'(dmem_req_write), 32'd0);
        end
        @(negedge clk);
        dmem_req_ready = 1'b0;
        #1;
        chk("load_wait1_state", 32'(state_dbg), 32'd5);
        chk("load_wait1_dreq", 32'(dmem_req_valid), 32'd0);
        @(negedge clk);
        dmem_resp_valid = 1'b1;
        #1;
        chk("load_wait2_state", 32'(state_dbg), 32'd5);
        chk("load_wait2_retire", 32'(retire), 32'd0);
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        #1;
        chk("load_wb_state", 32'(state_dbg), 32'd6);
        chk("load_wb_reg_write", 32'(reg_write), 32'd0);
        chk("load_wb_wb_sel", 32'(wb_sel), 32'd1);
        chk("load_wb_retire", 32'(retire), 32'd1);
        @(negedge clk);
        #1;
        chk("load_retire_count", 32'(retire_count), 32'd2);
        chk("load_next_retire", 32'(retire), 32'd0);

        // ---------------- BEQ taken ----------------
        fetch_instr(OPC_BRANCH, 5'd7, 1'b1);
        @(negedge clk);
        branch_taken = 1'b1;
        #1;
        chk("beqt_state", 32'(state_dbg), 32'd3);
        chk("beqt_pc_write", 32'(pc_write), 32'd1);
        chk("beqt_pc_src", 32'(pc_src), 32'd1);
        chk("beqt_retire", 32'(retire), 32'd1);
        chk("beqt_reg_write", 32'(reg_write), 32'd0);
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        chk("beqt_next_state", 32'(state_dbg), 32'd0);
        chk("beqt_retire_count", 32'(retire_count), 32'd3);

        // ---------------- BEQ not taken (count wraps to 0) ----------------
        fetch_instr(OPC_BRANCH, 5'd7, 1'b1);
        @(negedge clk);
        #1;
        chk("beqn_pc_src", 32'(pc_src), 32'd0);
        chk("beqn_pc_write", 32'(pc_write), 32'd1);
        chk("beqn_retire", 32'(retire), 32'd1);
        @(negedge clk);
        #1;
        chk("beqn_retire_count_wrap", 32'(retire_count), 32'd0);

        // ---------------- JAL x1 (fifth retire) ----------------
        fetch_instr(OPC_JAL, 5'd1, 1'b1);
        @(negedge clk);
        #1;
        chk("jal_exec_pc_write", 32'(pc_write), 32'd0);
        @(negedge clk);
        #1;
        chk("jal_wb_state", 32'(state_dbg), 32'd6);
        chk("jal_wb_reg_write", 32'(reg_write), 32'd1);
        chk("jal_wb_wb_sel", 32'(wb_sel), 32'd2);
        chk("jal_wb_pc_src", 32'(pc_src), 32'd1);
        chk("jal_wb_retire", 32'(retire), 32'd1);
        @(negedge clk);
        #1;
        chk("five_retires_count", 32'(retire_count), 32'd1);

        // ---------------- compressed word ----------------
        fetch_instr(OPC_LOAD, 5'd3, 1'b0);
        #1;
        chk("cmp_decode_dreq", 32'(dmem_req_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("cmp_state", 32'(state_dbg), 32'd7);
        chk("cmp_trap_valid", 32'(trap_valid), 32'd1);
        chk("cmp_trap_cause", 32'(trap_cause), 32'd2);
        chk("cmp_pc_src", 32'(pc_src), 32'd3);
        chk("cmp_retire", 32'(retire), 32'd0);
        chk("cmp_dreq", 32'(dmem_req_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("cmp_next_state", 32'(state_dbg), 32'd0);
        chk("cmp_cause_held", 32'(trap_cause), 32'd2);
        chk("cmp_retire_count", 32'(retire_count), 32'd1);

        // ---------------- unsupported opcode bit 31 ----------------
        fetch_instr(OPC_BAD, 5'd3, 1'b1);
        @(negedge clk);
        #1;
        chk("bad_state", 32'(state_dbg), 32'd7);
        chk("bad_trap_valid", 32'(trap_valid), 32'd1);
        chk("bad_trap_cause", 32'(trap_cause), 32'd2);
        chk("bad_retire", 32'(retire), 32'd0);
        @(negedge clk);

        // ---------------- SYSTEM ----------------
        fetch_instr(OPC_SYSTEM, 5'd0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("sys_state", 32'(state_dbg), 32'd7);
        chk("sys_trap_cause", 32'(trap_cause), 32'd3);
        @(negedge clk);

        // ---------------- imem never responds ----------------
        imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            imem_req_ready = 1'b0;
            #1;
            chk("itmo_wait_state", 32'(state_dbg), 32'd1);
            chk("itmo_wait_trap", 32'(trap_valid), 32'd0);
        end
        @(negedge clk);
        #1;
        chk("itmo_state", 32'(state_dbg), 32'd7);
        chk("itmo_trap_valid", 32'(trap_valid), 32'd1);
        chk("itmo_trap_cause", 32'(trap_cause), 32'd1);
        chk("itmo_pc_src", 32'(pc_src), 32'd3);
        @(negedge clk);
        #1;
        chk("itmo_next_state", 32'(state_dbg), 32'd0);

        // ---------------- imem response on the 4th wait cycle ----------------
        imem_req_ready = 1'b1;
        opcode_decode  = OPC_OP_IMM;
        rd_address     = 5'd2;
        instr_is_32    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            imem_req_ready  = 1'b0;
            imem_resp_valid = (i == 3);
            #1;
            chk("iedge_trap", 32'(trap_valid), 32'd0);
        end
        chk("iedge_ir_load", 32'(ir_load), 32'd1);
        @(negedge clk);
        imem_resp_valid = 1'b0;
        #1;
        chk("iedge_decode_state", 32'(state_dbg), 32'd2);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("iedge_wb_retire", 32'(retire), 32'd1);
        @(negedge clk);
        #1;
        chk("iedge_retire_count", 32'(retire_count), 32'd2);
        chk("iedge_cause_held", 32'(trap_cause), 32'd1);

        // ---------------- STORE with data timeout ----------------
        fetch_instr(OPC_STORE, 5'd0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        dmem_req_ready = 1'b1;
        #1;
        chk("sto_dreq_valid", 32'(dmem_req_valid), 32'd1);
        chk("sto_dreq_write", 32'(dmem_req_write), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dmem_req_ready = 1'b0;
            #1;
            chk("dtmo_wait_state", 32'(state_dbg), 32'd5);
        end
        @(negedge clk);
        #1;
        chk("dtmo_state", 32'(state_dbg), 32'd7);
        chk("dtmo_trap_cause", 32'(trap_cause), 32'd4);
        chk("dtmo_trap_valid", 32'(trap_valid), 32'd1);
        @(negedge clk);

        // ---------------- reset during STORE MEM_WAIT ----------------
        fetch_instr(OPC_STORE, 5'd0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        #1;
        chk("rstmw_state", 32'(state_dbg), 32'd5);
        chk("rstmw_count_before", 32'(retire_count), 32'd2);
        rst_n           = 1'b0;
        dmem_resp_valid = 1'b1;
        #1;
        chk("rstmw_pc_write", 32'(pc_write), 32'd0);
        chk("rstmw_retire", 32'(retire), 32'd0);
        chk("rstmw_dreq", 32'(dmem_req_valid), 32'd0);
        chk("rstmw_imem_req", 32'(imem_req_valid), 32'd0);
        chk("rstmw_trap_valid", 32'(trap_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstmw_after_state", 32'(state_dbg), 32'd0);
        chk("rstmw_after_count", 32'(retire_count), 32'd0);
        chk("rstmw_after_cause", 32'(trap_cause), 32'd0);
        chk("rstmw_after_imem_req", 32'(imem_req_valid), 32'd1);
        chk("rstmw_after_retire", 32'(retire), 32'd0);
        @(negedge clk);
        dmem_resp_valid = 1'b0;
        #1;
        chk("rstmw_stale_dropped", 32'(state_dbg), 32'd0);
        chk("rstmw_stale_count", 32'(retire_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_control_fsm.md
Name: core_control_fsm

Overview:
- Multi-cycle sequencer for the RV32I core. Drives instruction fetch, latches the instruction register that feeds the instruction decoder, and classifies the decoded one-hot opcode.
- Sequences data-memory access, register writeback, PC update and traps.
- Sits between the imem/dmem handshake ports and the decoder/ALU/register-file datapath.
- Exactly one instruction is in flight at a time.

Parameters:
- MEM_TIMEOUT, 255, max cycles to wait in a memory-wait state before trapping; 0 disables the timeout.
- RETIRE_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  fetch request accepted
- imem_resp_valid  in  1  fetch data valid
- imem_resp_fault  in  1  fetch bus error, qualified by imem_resp_valid
- ir_load  out  1  latch fetch data into IR
- instr_is_32  in  1  IR[1:0]==2'b11
- opcode_decode  in  32  one-hot opcode[6:2] from the decoder
- rd_address  in  5  decoded rd
- branch_taken  in  1  branch comparator result
- dmem_req_valid  out  1  data request
- dmem_req_write  out  1  1 = store
- dmem_req_ready  in  1  data request accepted
- dmem_resp_valid  in  1  load data / store ack
- reg_write  out  1  register-file write enable
- wb_sel  out  2  0 ALU, 1 load data, 2 PC+4
- pc_write  out  1  PC update strobe
- pc_src  out  2  0 PC+4, 1 PC+imm, 2 rs1+imm, 3 trap vector
- trap_valid  out  1  one-cycle trap pulse
- trap_cause  out  3  last trap cause
- retire  out  1  one-cycle instruction-complete pulse
- retire_count  out  RETIRE_W  retired-instruction count
- state_dbg  out  3  current state encoding

Behaviour:
- **Reset:**
  - rst_n sampled low at a rising edge forces state FETCH_REQ, retire_count 0, trap_cause 0 and timeout counter 0. This applies in any state, including mid-handshake.
  - Any outstanding memory response is dropped.
  - All strobes are 0 while rst_n is low.
- **Output timing:** strobes are combinational from the registered state plus the listed inputs. All are 0 in every state/condition not listed below.
- **Supported opcode bits:** 0 LOAD, 3 MISC_MEM, 4 OP_IMM, 5 AUIPC, 8 STORE, 12 OP, 13 LUI, 24 BRANCH, 25 JALR, 27 JAL, 28 SYSTEM.
- **FETCH_REQ:**
  - imem_req_valid=1, held until imem_req_ready.
  - On ready, go to FETCH_WAIT and clear the timeout counter.
- **FETCH_WAIT:**
  - resp_valid with fault=0: ir_load=1, go to DECODE.
  - resp_valid with fault=1: no ir_load, go to TRAP with cause 1.
  - Timeout counter reaches MEM_TIMEOUT with no response: TRAP with cause 1.
- **DECODE:** one cycle for decoder settle.
  - instr_is_32=0: TRAP with cause 2. Compressed encodings present opcode_decode bit 0 and must not be treated as LOAD.
  - No supported bit set in opcode_decode: TRAP with cause 2.
  - Otherwise go to EXECUTE.
- **EXECUTE:**
  - LOAD or STORE: go to MEM_REQ.
  - SYSTEM: TRAP with cause 3.
  - BRANCH: pc_write=1, pc_src = branch_taken ? 1 : 0, retire=1, go to FETCH_REQ.
  - MISC_MEM (fence = nop): pc_write=1, pc_src=0, retire=1, go to FETCH_REQ.
  - All others: go to WRITEBACK.
- **MEM_REQ:**
  - dmem_req_valid=1 and dmem_req_write=STORE, both held until dmem_req_ready.
  - On ready, go to MEM_WAIT and clear the timeout counter.
- **MEM_WAIT:**
  - resp_valid for a LOAD: go to WRITEBACK.
  - resp_valid for a STORE: pc_write=1, pc_src=0, retire=1, go to FETCH_REQ.
  - Timeout: TRAP with cause 4.
- **WRITEBACK:**
  - reg_write=1 only if rd_address!=0.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc_write=1, pc_src: 1 for JAL, 2 for JALR, 0 otherwise.
  - retire=1, go to FETCH_REQ.
- **TRAP:**
  - trap_valid=1, pc_write=1, pc_src=3, no retire.
  - trap_cause updates on entry and holds until the next trap.
  - Next state FETCH_REQ.
- **Timeout counter:**
  - Increments each cycle in FETCH_WAIT/MEM_WAIT without a response; saturates at MEM_TIMEOUT.
  - A response arriving in the same cycle the count reaches MEM_TIMEOUT wins: no trap.
- **retire_count:** increments on retire and wraps modulo 2^RETIRE_W.
- **Latency:**
  - ALU op with zero-wait memory: 5 cycles (FETCH_REQ, FETCH_WAIT, DECODE, EXECUTE, WRITEBACK).
  - Load with zero-wait memory: 7 cycles.

Decomposition:
- Package core_ctrl_pkg holds:
  - state enum: FETCH_REQ=0, FETCH_WAIT=1, DECODE=2, EXECUTE=3, MEM_REQ=4, MEM_WAIT=5, WRITEBACK=6, TRAP=7;
  - pc_src and wb_sel encodings;
  - trap cause codes: 1 fetch fault/timeout, 2 illegal, 3 system, 4 data timeout;
  - opcode bit-index constants.
- One sub-module, ctrl_timeout_counter: clear / enable / done, parameterised by MEM_TIMEOUT.

Test Plan:
- **ADDI, zero-wait imem:** required response:
  - retire high exactly on cycle 5 after reset release;
  - reg_write=1, wb_sel=0, pc_src=0;
  - retire_count=1.
- **LOAD, rd=x0, dmem_req_ready delayed 3 cycles, resp 2 cycles later:** required response:
  - dmem_req_valid held 4 cycles;
  - WRITEBACK with reg_write=0, wb_sel=1;
  - retire once.
- **Branches:** required response:
  - BEQ with branch_taken=1: pc_src=1, no reg_write.
  - BEQ with branch_taken=0: pc_src=0.
  - JAL rd=x1: wb_sel=2, pc_src=1.
- **Illegal instructions:** required response:
  - compressed word (instr_is_32=0, opcode_decode bit 0): trap_valid=1, trap_cause=2, no dmem_req_valid, no retire.
  - opcode_decode=1<<31: same result.
- **MEM_TIMEOUT=4, imem never responds:** required response:
  - TRAP entered on cycle 4 in FETCH_WAIT, cause 1, pc_src=3.
  - Repeat with the response arriving exactly on cycle 4: no trap.
- **Reset and counter wrap:** required response:
  - rst_n low during MEM_WAIT of a STORE: next state FETCH_REQ, all strobes 0, retire_count 0.
  - With RETIRE_W=2, 5 retires: retire_count=1.
